// File: rtl/vr_modctr_dec_pkg.sv
// vr_modctr_dec_pkg: shared constants and the clog2 helper for the modulo counter/decoder
package vr_modctr_dec_pkg;
    localparam int DEF_MODULUS = 8;
    localparam int DEF_WIDTH = 3;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/vr_onehot_dec_l.sv
// vr_onehot_dec_l: combinational active-low one-hot decoder, y[i]=0 iff sel==i
module vr_onehot_dec_l #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [W-1:0] sel,
    output logic [0:N-1] y
);
    always_comb
        for (int i = 0; i < N; i++) y[i] = sel != W'(i);
endmodule

// File: rtl/vr_modctr_dec.sv
// vr_modctr_dec: up/down modulo counter with load, registered active-low decode and terminal count
module vr_modctr_dec
    import vr_modctr_dec_pkg::*;
#(
    parameter int MODULUS = DEF_MODULUS,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               EN,
    input  logic               UP,
    input  logic               LD,
    input  logic [WIDTH-1:0]   D,
    output logic [WIDTH-1:0]   Q,
    output logic [0:MODULUS-1] S_L,
    output logic               TC_L,
    output logic               ERR
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [0:MODULUS-1] S_RST = {1'b0, {(MODULUS - 1) {1'b1}}};
    if (MODULUS < 2 || MODULUS > 256 || WIDTH < clog2(MODULUS)) begin : g_bad_params
        $error("vr_modctr_dec: illegal MODULUS/WIDTH combination");
    end
    logic ld_bad, at_end;
    logic [WIDTH-1:0] q_nxt;
    logic [0:MODULUS-1] s_nxt;
    // extra bit so MODULUS == 2**WIDTH still compares correctly
    assign ld_bad = LD && ({1'b0, D} >= (WIDTH + 1)'(MODULUS));
    assign at_end = UP ? Q == MAX : Q == '0;
    always_comb
        q_nxt = LD ? (ld_bad ? Q : D)
              : EN ? (UP ? (Q == MAX ? '0 : Q + WIDTH'(1)) : (Q == '0 ? MAX : Q - WIDTH'(1)))
              : Q;
    vr_onehot_dec_l #(.N(MODULUS), .W(WIDTH)) u_dec (.sel(q_nxt), .y(s_nxt));
    always_ff @(posedge CLK) begin
        if (CLR) begin
            Q <= '0;
            S_L <= S_RST;
            ERR <= 1'b0;
        end else begin
            Q <= q_nxt;
            S_L <= s_nxt;
            ERR <= ld_bad;
        end
    end
    assign TC_L = ~(EN & ~LD & ~CLR & at_end);
endmodule

// File: tb/tb_vr_modctr_dec.sv
// tb_vr_modctr_dec: directed plus random checks of vr_modctr_dec (MODULUS=6) against an arithmetic model
module tb_vr_modctr_dec;
    localparam int M = 6;
    localparam int W = 3;
    logic CLK, CLR, EN, UP, LD;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [0:M-1] S_L;
    logic TC_L, ERR;
    int total, passes;
    int mq;
    bit merr, reset_done;

    vr_modctr_dec #(.MODULUS(M), .WIDTH(W)) dut (
        .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP), .LD(LD), .D(D),
        .Q(Q), .S_L(S_L), .TC_L(TC_L), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [0:M-1] exp_s(input int q);
        logic [0:M-1] s;
        for (int i = 0; i < M; i++) s[i] = (i != q);
        return s;
    endfunction

    // exactly one low decode bit in every cycle once reset has happened
    always @(negedge CLK)
        if (reset_done) chk("onehot_l", 32'($countones(~S_L)), 32'd1);

    task automatic step(input bit clr, input bit en, input bit up, input bit ld, input int d);
        bit tc;
        CLR = clr; EN = en; UP = up; LD = ld; D = W'(d);
        #1;
        tc = en && !ld && !clr && (up ? mq == M - 1 : mq == 0);
        if (reset_done) chk("tc_l", 32'(TC_L), 32'(!tc));
        @(posedge CLK);
        if (clr) begin
            mq = 0; merr = 0;
        end else if (ld) begin
            merr = d >= M;
            if (d < M) mq = d;
        end else begin
            merr = 0;
            if (en) mq = up ? (mq + 1) % M : (mq + M - 1) % M;
        end
        #1;
        chk("q", 32'(Q), 32'(mq));
        chk("s_l", 32'(S_L), 32'(exp_s(mq)));
        chk("err", 32'(ERR), 32'(merr));
        reset_done = 1;
    endtask

    initial begin
        total = 0; passes = 0; mq = 0; merr = 0; reset_done = 0;
        CLR = 0; EN = 0; UP = 0; LD = 0; D = '0;
        step(1, 0, 0, 0, 0);
        chk("reset_s_l", 32'(S_L), 32'(6'b011111));
        repeat (7) step(0, 1, 1, 0, 0);
        chk("up_wrap_q", 32'(Q), 32'd1);
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        chk("down_wrap_q", 32'(Q), 32'd3);
        repeat (5) step(0, 0, 1, 0, 0);
        chk("hold_q", 32'(Q), 32'd3);
        chk("hold_tc_l", 32'(TC_L), 32'd1);
        step(0, 1, 1, 1, 4);
        chk("load4_s_l", 32'(S_L), 32'(6'b111101));
        step(1, 1, 1, 1, 7);
        chk("clr_over_ld_s_l", 32'(S_L), 32'(6'b011111));
        chk("clr_over_ld_err", 32'(ERR), 32'd0);
        step(0, 0, 0, 1, 2);
        step(0, 1, 1, 1, 7);
        chk("bad_ld_q", 32'(Q), 32'd2);
        chk("bad_ld_err", 32'(ERR), 32'd1);
        step(0, 0, 1, 0, 0);
        chk("err_pulse_end", 32'(ERR), 32'd0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("dir_change_q", 32'(Q), 32'd2);
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 4) == 0, int'($urandom_range(0, 7)));
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
